// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared grant encodings and default sizes for the data-memory arbiter
package mem_arb_pkg;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports A/B plus the data-memory side of the arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              AReq, AWe, AAck, AErr, ARValid;
    logic [31:0]       AAddr;
    logic [DATA_W-1:0] AWData, ARData;
    logic              BReq, BWe, BLock, BAck, BErr, BRValid;
    logic [31:0]       BAddr;
    logic [DATA_W-1:0] BWData, BRData;
    logic [31:0]       MemAddress;
    logic [DATA_W-1:0] MemWriteData, MemReadData;
    logic              MemRead, MemWrite;
    modport slave (
        input  AReq, AWe, AAddr, AWData, BReq, BWe, BAddr, BWData, BLock, MemReadData,
        output AAck, AErr, ARValid, ARData, BAck, BErr, BRValid, BRData,
               MemAddress, MemWriteData, MemRead, MemWrite
    );
    modport master (
        output AReq, AWe, AAddr, AWData, BReq, BWe, BAddr, BWData, BLock, MemReadData,
        input  AAck, AErr, ARValid, ARData, BAck, BErr, BRValid, BRData,
               MemAddress, MemWriteData, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; a held lock makes B the only eligible port
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic  areq,
    input  logic  breq,
    input  port_e last_grant,
    input  logic  locked,
    output logic  valid,
    output port_e gnt
);
    logic a_ok;
    always_comb begin
        a_ok  = areq & ~locked;
        valid = a_ok | breq;
        gnt   = (a_ok & breq) ? port_e'(~last_grant) : (breq ? PORT_B : PORT_A);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read data memory between fetch port A and load/store port B
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input logic          Clk,
    input logic          Rst_n,
    mem_arbiter_if.slave bus
);
    port_e       last_grant, gnt;
    logic        locked, valid, ack_a, ack_b, in_range, sel_we, a_rv, b_rv;
    logic [31:0] sel_addr;

    rr_arb2 u_arb (
        .areq       (bus.AReq),
        .breq       (bus.BReq),
        .last_grant (last_grant),
        .locked     (locked),
        .valid      (valid),
        .gnt        (gnt)
    );

    // With no grant the mux rests on port A, so the memory bus is never left floating
    always_comb begin
        ack_a            = Rst_n & valid & (gnt == PORT_A);
        ack_b            = Rst_n & valid & (gnt == PORT_B);
        sel_addr         = ack_b ? bus.BAddr : bus.AAddr;
        sel_we           = ack_b ? bus.BWe : bus.AWe;
        in_range         = sel_addr < 32'(DEPTH);
        bus.AAck         = ack_a;
        bus.BAck         = ack_b;
        bus.AErr         = ack_a & ~in_range;
        bus.BErr         = ack_b & ~in_range;
        bus.MemAddress   = sel_addr;
        bus.MemWriteData = ack_b ? bus.BWData : bus.AWData;
        bus.MemRead      = (ack_a | ack_b) & in_range & ~sel_we;
        bus.MemWrite     = (ack_a | ack_b) & in_range & sel_we;
        bus.ARValid      = a_rv;
        bus.BRValid      = b_rv;
        bus.ARData       = bus.MemReadData;
        bus.BRData       = bus.MemReadData;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_grant <= PORT_B;
            locked     <= 1'b0;
            a_rv       <= 1'b0;
            b_rv       <= 1'b0;
        end else begin
            if (valid) last_grant <= gnt;
            if (ack_b) locked <= bus.BLock;
            a_rv <= ack_a & in_range & ~sel_we;
            b_rv <= ack_b & in_range & ~sel_we;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plan plus randomized traffic checked against a behavioural arbiter/memory model
module tb_mem_arbiter;
    localparam int DEPTH = 32;
    logic Clk = 1'b0;
    logic Rst_n;
    mem_arbiter_if #(.DATA_W(32)) bus ();
    mem_arbiter #(.DEPTH(DEPTH)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    always #5 Clk = ~Clk;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    always @(posedge Clk) begin
        if (bus.MemWrite) mem[bus.MemAddress[4:0]] <= bus.MemWriteData;
        if (bus.MemRead) bus.MemReadData <= mem[bus.MemAddress[4:0]];
    end

    int checks = 0, failures = 0;
    int m_last;          // 0 = A granted most recently, 1 = B
    bit m_locked, m_rv_a, m_rv_b;
    logic [31:0] m_rd_a, m_rd_b;
    logic obs_aack, obs_back, obs_aerr, obs_berr, obs_arv, obs_brv, obs_memrd, obs_memwr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_rv_a = 0; m_rv_b = 0;
    endtask

    task automatic eval();
        bit ea, eb, wa, wb, inr, we;
        logic [31:0] ad, wd;
        obs_aack = bus.AAck; obs_back = bus.BAck; obs_aerr = bus.AErr; obs_berr = bus.BErr;
        obs_arv = bus.ARValid; obs_brv = bus.BRValid; obs_memrd = bus.MemRead; obs_memwr = bus.MemWrite;
        if (!Rst_n) begin
            check("rst_aack", {31'd0, bus.AAck}, 0);
            check("rst_back", {31'd0, bus.BAck}, 0);
            check("rst_err", {30'd0, bus.AErr, bus.BErr}, 0);
            check("rst_rv", {30'd0, bus.ARValid, bus.BRValid}, 0);
            check("rst_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 0);
            model_reset();
            return;
        end
        check("arvalid", {31'd0, bus.ARValid}, {31'd0, m_rv_a});
        check("brvalid", {31'd0, bus.BRValid}, {31'd0, m_rv_b});
        if (m_rv_a) check("ardata", bus.ARData, m_rd_a);
        if (m_rv_b) check("brdata", bus.BRData, m_rd_b);
        ea = bus.AReq && !m_locked;
        eb = bus.BReq;
        wa = ea && (!eb || m_last == 1);
        wb = eb && !wa;
        ad = wb ? bus.BAddr : bus.AAddr;
        wd = wb ? bus.BWData : bus.AWData;
        we = wb ? bus.BWe : bus.AWe;
        inr = ad < DEPTH;
        check("aack", {31'd0, bus.AAck}, {31'd0, wa});
        check("back", {31'd0, bus.BAck}, {31'd0, wb});
        check("aerr", {31'd0, bus.AErr}, {31'd0, wa && !inr});
        check("berr", {31'd0, bus.BErr}, {31'd0, wb && !inr});
        check("memread", {31'd0, bus.MemRead}, {31'd0, (wa || wb) && inr && !we});
        check("memwrite", {31'd0, bus.MemWrite}, {31'd0, (wa || wb) && inr && we});
        if ((wa || wb) && inr) check("memaddr", bus.MemAddress, ad);
        if ((wa || wb) && inr && we) check("memwdata", bus.MemWriteData, wd);
        m_rv_a = wa && inr && !we;
        m_rv_b = wb && inr && !we;
        if (inr) begin
            m_rd_a = ref_mem[ad[4:0]];
            m_rd_b = ref_mem[ad[4:0]];
            if ((wa || wb) && we) ref_mem[ad[4:0]] = wd;
        end
        if (wa || wb) m_last = wb ? 1 : 0;
        if (wb) m_locked = bus.BLock;
    endtask

    task automatic step();
        @(negedge Clk);
        eval();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.AReq = req; bus.AWe = we; bus.AAddr = addr; bus.AWData = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic lk);
        bus.BReq = req; bus.BWe = we; bus.BAddr = addr; bus.BWData = wd; bus.BLock = lk;
    endtask

    initial begin
        int diffs;
        bit exp_a;
        Rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        bus.MemReadData = '0;
        set_a(1, 0, 1, 0);
        set_b(1, 1, 2, 32'h55, 1);
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        eval();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        // contention: expect A, B, A, B with RValid trailing each ack by one cycle
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_a = (i % 2) == 0;
            check("cont_aack", {31'd0, obs_aack}, {31'd0, exp_a});
            check("cont_back", {31'd0, obs_back}, {31'd0, !exp_a});
            if (i > 0) check("cont_rv", {30'd0, obs_arv, obs_brv}, exp_a ? 32'd1 : 32'd2);
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        check("cont_last_brv", {31'd0, obs_brv}, 1);
        // single read of preloaded word
        set_a(1, 0, 5, 0);
        step();
        check("rd_aack", {31'd0, obs_aack}, 1);
        check("rd_memread", {31'd0, obs_memrd}, 1);
        set_a(0, 0, 0, 0);
        @(negedge Clk);
        check("rd_data", bus.ARData, 32'hDEADBEEF);
        check("rd_brv", {31'd0, bus.BRValid}, 0);
        eval();
        @(posedge Clk);
        #1;
        // locked read-modify-write from B while A keeps asking
        set_a(1, 0, 7, 0);
        set_b(1, 0, 3, 0, 1);
        step();
        check("lock_rd_back", {31'd0, obs_back}, 1);
        check("lock_rd_aack", {31'd0, obs_aack}, 0);
        set_b(1, 1, 3, 32'h12345678, 0);
        step();
        check("lock_wr_back", {31'd0, obs_back}, 1);
        check("lock_wr_aack", {31'd0, obs_aack}, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        check("lock_rel_aack", {31'd0, obs_aack}, 1);
        set_a(0, 0, 0, 0);
        step();
        // out-of-range write from B
        set_b(1, 1, 32, 32'hBAD0BAD0, 0);
        step();
        check("oor_back", {31'd0, obs_back}, 1);
        check("oor_berr", {31'd0, obs_berr}, 1);
        check("oor_memwr", {31'd0, obs_memwr}, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        check("oor_brv", {31'd0, obs_brv}, 0);
        check("oor_mem0", mem[0], ref_mem[0]);
        // reset in the cycle after an A read grant
        set_a(1, 0, 9, 0);
        step();
        set_a(0, 0, 0, 0);
        Rst_n = 1'b0;
        #1;
        check("rstmid_arv", {31'd0, bus.ARValid}, 0);
        step();
        Rst_n = 1'b1;
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0, 0);
        step();
        check("rstmid_first_a", {31'd0, obs_aack}, 1);
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        // randomized traffic; requests are held until acknowledged
        for (int c = 0; c < 400; c++) begin
            if (!bus.AReq || obs_aack)
                set_a($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 35), $urandom);
            if (!bus.BReq || obs_back)
                set_b($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 35), $urandom,
                      $urandom_range(0, 3) == 0);
            step();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", diffs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
